// File: rtl/noc_output_arbiter_if.sv
// Handshake bundle between the four router input streams and the shared output link.
// The arbiter takes the slave view; the traffic source/sink side takes the master view.
interface noc_output_arbiter_if #(
    parameter int WIDTH_PACKET = 57,
    parameter int NUM_IN       = 4
);
    logic [NUM_IN-1:0]              in_valid;
    logic [NUM_IN*WIDTH_PACKET-1:0] in_data;
    logic [NUM_IN-1:0]              in_ready;
    logic                           out_valid;
    logic [WIDTH_PACKET-1:0]        out_data;
    logic                           out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/noc_output_arbiter.sv
// Round-robin merge of four input packet streams onto one registered output slot.
// Define NOC_OUTARB_STATS_EN to add per-input 16-bit wrapping grant counters (grant_count).
`ifdef NOC_OUTARB_STATS_EN
module noc_outarb_lane_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc,
    output logic [15:0] cnt
);
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;
endmodule
`endif

module noc_output_arbiter #(
    parameter int WIDTH_PACKET = 57,
    parameter int NUM_IN       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    noc_output_arbiter_if.slave    bus
`ifdef NOC_OUTARB_STATS_EN
    ,
    output logic [NUM_IN*16-1:0]   grant_count
`endif
);
    localparam int PTR_W = $clog2(NUM_IN);

    typedef struct packed {
        logic                    vld;
        logic [WIDTH_PACKET-1:0] data;
    } slot_t;

    slot_t                                slot_q, slot_d;
    logic [PTR_W-1:0]                     ptr_q, ptr_d;
    logic [NUM_IN-1:0][WIDTH_PACKET-1:0]  in_pkts;
    logic                                 slot_free;
    logic                                 gnt_any;
    logic [PTR_W-1:0]                     gnt_idx;
    logic [NUM_IN-1:0]                    gnt_vec;
    logic                                 accept;

    assign in_pkts   = bus.in_data;
    assign slot_free = !slot_q.vld || bus.out_ready;

    // Walk from the highest offset down so the requester nearest the pointer wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = ptr_q;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            idx = ptr_q + PTR_W'(k);
            if (bus.in_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign gnt_vec      = (rst_n && slot_free && gnt_any) ? (NUM_IN'(1) << gnt_idx) : '0;
    assign accept       = |gnt_vec;
    assign bus.in_ready = gnt_vec;

    always_comb begin
        slot_d = slot_q;
        ptr_d  = ptr_q;
        if (accept) begin
            slot_d.vld  = 1'b1;
            slot_d.data = in_pkts[gnt_idx];
            ptr_d       = gnt_idx + 1'b1;
        end else if (bus.out_ready) begin
            // Drain only clears valid; data stays as last sent.
            slot_d.vld = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= '0;
            ptr_q  <= '0;
        end else begin
            slot_q <= slot_d;
            ptr_q  <= ptr_d;
        end
    end

    assign bus.out_valid = slot_q.vld;
    assign bus.out_data  = slot_q.data;

`ifdef NOC_OUTARB_STATS_EN
    for (genvar i = 0; i < NUM_IN; i++) begin : g_cnt
        noc_outarb_lane_cnt u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (gnt_vec[i]),
            .cnt   (grant_count[i*16 +: 16])
        );
    end
`endif
endmodule

// File: tb/tb_noc_output_arbiter.sv
// Self-checking bench for noc_output_arbiter: directed scenarios plus randomized traffic
// against a queue-free reference model; grant counters checked when NOC_OUTARB_STATS_EN is defined.
module tb_noc_output_arbiter;
    localparam int W = 57;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_output_arbiter_if #(.WIDTH_PACKET(W), .NUM_IN(N)) bus ();

    logic [N-1:0]        src_valid = '0;
    logic [N-1:0][W-1:0] src_data  = '0;
    logic                out_rdy   = 1'b0;

    assign bus.in_valid  = src_valid;
    assign bus.in_data   = src_data;
    assign bus.out_ready = out_rdy;

`ifdef NOC_OUTARB_STATS_EN
    logic [N*16-1:0] grant_count;
`endif

    noc_output_arbiter #(.WIDTH_PACKET(W), .NUM_IN(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef NOC_OUTARB_STATS_EN
        ,
        .grant_count (grant_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic         m_ov  = 1'b0;
    logic [W-1:0] m_od  = '0;
    int           m_ptr = 0;
    int           m_cnt [N];
    logic [N-1:0] m_rdy;
    logic [N-1:0] obs_rdy;

    function automatic logic [N-1:0] ref_ready();
        int i;
        if (!rst_n) return '0;
        if (m_ov && !out_rdy) return '0;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (src_valid[i]) return N'(1) << i;
        end
        return '0;
    endfunction

    // One clock: sample in_ready, advance model at the edge, retire accepted sources.
    task automatic tick();
        #1;
        m_rdy   = ref_ready();
        obs_rdy = bus.in_ready;
        @(posedge clk);
        if (!rst_n) begin
            m_ov = 1'b0; m_od = '0; m_ptr = 0;
            for (int i = 0; i < N; i++) m_cnt[i] = 0;
        end else if (m_rdy != '0) begin
            for (int i = 0; i < N; i++) begin
                if (m_rdy[i]) begin
                    m_od  = src_data[i];
                    m_ov  = 1'b1;
                    m_ptr = (i + 1) % N;
                    m_cnt[i] = (m_cnt[i] + 1) % 65536;
                end
            end
        end else if (out_rdy) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++)
            if (obs_rdy[i] && src_valid[i]) src_valid[i] = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; src_valid = '0; out_rdy = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_rdy = 1'b1; src_valid = '1;
        for (int i = 0; i < N; i++) src_data[i] = W'(i);
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (obs_rdy !== 4'b0000) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", obs_rdy); end
            checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
            checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", bus.out_data); end
        end
`ifdef NOC_OUTARB_STATS_EN
        checks++; if (grant_count !== '0) begin errors++; $display("FAIL reset_grant_count: got %h want 0", grant_count); end
`endif
        src_valid = '0;
    endtask

    task automatic test_burst();
        logic [N-1:0] refilled;
        do_reset();
        out_rdy = 1'b1; refilled = '0;
        for (int i = 0; i < N; i++) begin src_data[i] = W'(i); src_valid[i] = 1'b1; end
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++; if (!$onehot(obs_rdy)) begin errors++; $display("FAIL burst_onehot[%0d]: got %b want one-hot", k, obs_rdy); end
            checks++; if (obs_rdy !== m_rdy) begin errors++; $display("FAIL burst_in_ready[%0d]: got %b want %b", k, obs_rdy, m_rdy); end
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL burst_out_valid[%0d]: got %b want 1", k, bus.out_valid); end
            checks++; if (bus.out_data !== W'(k)) begin errors++; $display("FAIL burst_out_data[%0d]: got %0d want %0d", k, bus.out_data, k); end
            for (int i = 0; i < N; i++)
                if (obs_rdy[i] && !refilled[i]) begin
                    src_data[i] = W'(i + 4); src_valid[i] = 1'b1; refilled[i] = 1'b1;
                end
        end
`ifdef NOC_OUTARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            checks++; if (grant_count[i*16 +: 16] !== 16'd2) begin errors++; $display("FAIL burst_grant_count[%0d]: got %0d want 2", i, grant_count[i*16 +: 16]); end
        end
`endif
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL burst_drain_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== W'(7)) begin errors++; $display("FAIL burst_drain_hold: got %0d want 7", bus.out_data); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin src_data[i] = W'(i); src_valid[i] = 1'b1; end
        repeat (3) tick();
        checks++; if (bus.out_data !== W'(2)) begin errors++; $display("FAIL bp_setup: got %0d want 2", bus.out_data); end
        out_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++; if (bus.out_data !== W'(2) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d want v=1 d=2", c, bus.out_valid, bus.out_data); end
            checks++; if (obs_rdy !== 4'b0000) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0000", c, obs_rdy); end
        end
        out_rdy = 1'b1;
        tick();
        checks++; if (obs_rdy !== 4'b1000) begin errors++; $display("FAIL bp_release_grant: got %b want 1000", obs_rdy); end
        checks++; if (bus.out_data !== W'(3) || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_data: got v=%b d=%0d want v=1 d=3", bus.out_valid, bus.out_data); end
        tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g;
        do_reset();
        out_rdy = 1'b1;
        src_data[0] = W'(100); src_data[3] = W'(300); src_valid = 4'b1001;
        for (int k = 0; k < 8; k++) begin
            exp_g = (k % 2 == 0) ? 4'b0001 : 4'b1000;
            tick();
            checks++; if (obs_rdy !== exp_g) begin errors++; $display("FAIL fair_grant[%0d]: got %b want %b", k, obs_rdy, exp_g); end
            checks++; if (bus.out_data !== m_od) begin errors++; $display("FAIL fair_data[%0d]: got %h want %h", k, bus.out_data, m_od); end
            if (!src_valid[0]) begin src_data[0] = W'(100 + k + 1); src_valid[0] = 1'b1; end
            if (!src_valid[3]) begin src_data[3] = W'(300 + k + 1); src_valid[3] = 1'b1; end
        end
        src_valid = '0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        out_rdy = 1'b1;
        src_data[1] = W'(10); src_valid = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (obs_rdy !== 4'b0010) begin errors++; $display("FAIL single_grant[%0d]: got %b want 0010", k, obs_rdy); end
            checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== W'(10 + k)) begin errors++; $display("FAIL single_data[%0d]: got v=%b d=%0d want v=1 d=%0d", k, bus.out_valid, bus.out_data, 10 + k); end
            if (k < 2) begin src_data[1] = W'(11 + k); src_valid[1] = 1'b1; end
        end
        for (int i = 0; i < N; i++) src_data[i] = W'(40 + i);
        src_valid = '1;
        tick();
        checks++; if (obs_rdy !== 4'b0100) begin errors++; $display("FAIL single_ptr: got %b want 0100", obs_rdy); end
        checks++; if (bus.out_data !== W'(42)) begin errors++; $display("FAIL single_ptr_data: got %0d want 42", bus.out_data); end
        src_valid = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_rdy = 1'b0;
        src_data[0] = W'(5); src_valid = 4'b0001;
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== W'(5)) begin errors++; $display("FAIL mid_setup: got v=%b d=%0d want v=1 d=5", bus.out_valid, bus.out_data); end
        src_data[1] = W'(6); src_valid = 4'b0010;
        tick();
        checks++; if (obs_rdy !== 4'b0000) begin errors++; $display("FAIL mid_stall: got %b want 0000", obs_rdy); end
        rst_n = 1'b0;
        tick();
        checks++; if (obs_rdy !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b want 0000", obs_rdy); end
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin errors++; $display("FAIL mid_rst_out: got v=%b d=%0d want v=0 d=0", bus.out_valid, bus.out_data); end
        rst_n = 1'b1; out_rdy = 1'b1;
        for (int i = 0; i < N; i++) src_data[i] = W'(20 + i);
        src_valid = '1;
        tick();
        checks++; if (obs_rdy !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", obs_rdy); end
        checks++; if (bus.out_data !== W'(20)) begin errors++; $display("FAIL mid_first_data: got %0d want 20", bus.out_data); end
        src_valid = '0;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if (!src_valid[i] && $urandom_range(0, 1) == 1) begin
                    src_data[i]  = W'({$urandom(), $urandom()});
                    src_valid[i] = 1'b1;
                end
            out_rdy = ($urandom_range(0, 3) != 0);
            tick();
            checks++; if (obs_rdy !== m_rdy) begin errors++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, obs_rdy, m_rdy); end
            checks++; if (bus.out_valid !== m_ov) begin errors++; $display("FAIL rand_out_valid[%0d]: got %b want %b", c, bus.out_valid, m_ov); end
            checks++; if (bus.out_data !== m_od) begin errors++; $display("FAIL rand_out_data[%0d]: got %h want %h", c, bus.out_data, m_od); end
        end
`ifdef NOC_OUTARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            checks++; if (grant_count[i*16 +: 16] !== 16'(m_cnt[i])) begin errors++; $display("FAIL rand_grant_count[%0d]: got %0d want %0d", i, grant_count[i*16 +: 16], m_cnt[i]); end
        end
`endif
    endtask

    initial begin
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        test_reset();
        test_burst();
        test_backpressure();
        test_fairness();
        test_single();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
